// File: rtl/qc_ldpc_stream_encoder.sv
// Streaming QC-LDPC parity accumulator: rotates each info sub-block per proto-matrix row and XOR-accumulates, then streams the row sums.
// Optional build macro QCLDPC_ZSEL_CHECK_EN rejects a non-one-hot req_z in IDLE and pulses cfg_err.
module qc_ldpc_stream_encoder #(
  parameter int NUM_Z               = 3,
  parameter int MAX_Z               = 81,
  parameter int NUM_INFO_BLKS       = 20,
  parameter int NUM_PAR_BLKS        = 4,
  parameter int Z_VALUES [NUM_Z]    = '{27, 54, 81},
  parameter int SHIFT_W             = $clog2(MAX_Z) + 1
) (
  input  logic                                        CLK,
  input  logic                                        rst_n,
  input  logic                                        en,
  input  logic                                        abort,
  input  logic [NUM_Z-1:0]                            req_z,
  output logic                                        cfg_err,
  input  logic                                        s_valid,
  output logic                                        s_ready,
  input  logic [MAX_Z-1:0]                            s_data,
  output logic [$clog2(NUM_Z*NUM_INFO_BLKS)-1:0]      rom_addr,
  input  logic [NUM_PAR_BLKS*SHIFT_W-1:0]             rom_shift,
  output logic                                        m_valid,
  input  logic                                        m_ready,
  output logic [MAX_Z-1:0]                            m_data,
  output logic [$clog2(NUM_PAR_BLKS):0]               m_idx,
  output logic                                        m_last
);

  localparam int ADDR_W = $clog2(NUM_Z*NUM_INFO_BLKS);
  localparam int COL_W  = $clog2(NUM_INFO_BLKS+1);
  localparam int IDX_W  = $clog2(NUM_PAR_BLKS) + 1;
  localparam int ZI_W   = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                               state, state_nx;
  logic [COL_W-1:0]                     col, col_base;
  logic [IDX_W-1:0]                     out_idx;
  logic [ZI_W-1:0]                      z_idx, z_live, z_sel;
  logic [NUM_PAR_BLKS-1:0][MAX_Z-1:0]   acc;
  logic                                 accept, out_hs, last_beat, zsel_ok;
  int                                   z_cur;

  function automatic logic [ZI_W-1:0] lowest_set(input logic [NUM_Z-1:0] v);
    logic [ZI_W-1:0] idx;
    idx = '0;
    for (int i = NUM_Z-1; i >= 0; i--)
      if (v[i]) idx = ZI_W'(i);
    return idx;
  endfunction

  function automatic int z_of(input logic [ZI_W-1:0] idx);
    int z;
    z = Z_VALUES[0];
    for (int i = 0; i < NUM_Z; i++)
      if (idx == ZI_W'(i)) z = Z_VALUES[i];
    return z;
  endfunction

  // Cyclic right rotation within the low z bits; a shift of all-ones or >= z is a null block.
  function automatic logic [MAX_Z-1:0] rot(input logic [MAX_Z-1:0] x,
                                           input logic [SHIFT_W-1:0] s, input int z);
    logic [MAX_Z-1:0] y;
    int src;
    y = '0;
    if (s != '1 && int'(s) < z)
      for (int k = 0; k < MAX_Z; k++)
        if (k < z) begin
          src = k + int'(s);
          if (src >= z) src = src - z;
          y[k] = x[src];
        end
    return y;
  endfunction

  assign z_live    = lowest_set(req_z);
  assign z_sel     = (state == IDLE) ? z_live : z_idx;
  assign z_cur     = z_of(z_sel);
  assign col_base  = (state == IDLE) ? '0 : col;
  assign rom_addr  = ADDR_W'(int'(z_sel) * NUM_INFO_BLKS + int'(col_base));
  assign last_beat = (col_base == COL_W'(NUM_INFO_BLKS-1));
  assign m_idx     = out_idx;

`ifdef QCLDPC_ZSEL_CHECK_EN
  assign zsel_ok = $onehot(req_z);
  assign cfg_err = rst_n && (state == IDLE) && s_valid && !zsel_ok;
`else
  assign zsel_ok = 1'b1;
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    case (state)
      IDLE:   s_ready = rst_n && en && zsel_ok;
      ACCUM:  s_ready = en;
      OUTPUT: begin
        m_valid = 1'b1;
        m_last  = (out_idx == IDX_W'(NUM_PAR_BLKS-1));
      end
      default: ;
    endcase
    accept = s_valid && s_ready && !abort;
    out_hs = m_valid && m_ready && !abort;
    if (accept) state_nx = last_beat ? OUTPUT : ACCUM;
    if (out_hs && m_last) state_nx = IDLE;
    if (abort) state_nx = IDLE;
  end

  always_comb begin
    m_data = '0;
    for (int r = 0; r < NUM_PAR_BLKS; r++)
      if (state == OUTPUT && out_idx == IDX_W'(r)) m_data = acc[r];
  end

  // Accumulate stage: first beat overwrites, later beats XOR into the row sums.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col     <= '0;
      out_idx <= '0;
      z_idx   <= '0;
      acc     <= '0;
    end else begin
      state <= state_nx;
      if (abort) begin
        col     <= '0;
        out_idx <= '0;
      end else begin
        if (accept) begin
          col <= last_beat ? '0 : col_base + COL_W'(1);
          if (state == IDLE) z_idx <= z_live;
          for (int r = 0; r < NUM_PAR_BLKS; r++)
            acc[r] <= ((state == IDLE) ? '0 : acc[r]) ^
                      rot(s_data, rom_shift[r*SHIFT_W +: SHIFT_W], z_cur);
        end
        if (out_hs) out_idx <= m_last ? '0 : out_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_qc_ldpc_stream_encoder.sv
// Directed bench for qc_ldpc_stream_encoder: shift ROM modelled as a table, expected parity computed by hand.
module tb_qc_ldpc_stream_encoder;

  logic        CLK = 1'b0;
  logic        rst_n, en, abort, cfg_err;
  logic [2:0]  req_z;
  logic        s_valid, s_ready, m_valid, m_ready, m_last;
  logic [80:0] s_data, m_data;
  logic [5:0]  rom_addr;
  logic [31:0] rom_shift;
  logic [2:0]  m_idx;

  logic [7:0]  shift_tab [64][4];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 CLK = ~CLK;

  qc_ldpc_stream_encoder dut (
    .CLK(CLK), .rst_n(rst_n), .en(en), .abort(abort), .req_z(req_z), .cfg_err(cfg_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rom_addr(rom_addr), .rom_shift(rom_shift),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last)
  );

  always_comb begin
    rom_shift = '0;
    for (int r = 0; r < 4; r++) rom_shift[r*8 +: 8] = shift_tab[rom_addr][r];
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic fill_tab(input int lo, input int hi, input logic [7:0] v);
    for (int a = lo; a <= hi; a++)
      for (int r = 0; r < 4; r++) shift_tab[a][r] = v;
  endtask

  task automatic send_beat(input logic [80:0] d);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (!s_ready && w < 50) begin
      @(negedge CLK); #1; w++;
    end
    if (!s_ready) chk("s_ready_wait", s_ready, 1);
    @(negedge CLK);
  endtask

  task automatic recv(input logic [80:0] e0, e1, e2, e3, input int stall);
    logic [80:0] e [4];
    int w;
    e = '{e0, e1, e2, e3};
    m_ready = (stall == 0);
    #1;
    chk("m_valid_latency", m_valid, 1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_m_valid", m_valid, 1);
      chk("stall_m_idx", m_idx, 0);
      chk("stall_m_data", m_data, e0);
      chk("stall_s_ready", s_ready, 0);
      @(negedge CLK); #1;
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!m_valid && w < 20) begin
        @(negedge CLK); #1; w++;
      end
      chk($sformatf("m_valid[%0d]", i), m_valid, 1);
      chk($sformatf("m_idx[%0d]", i), m_idx, i);
      chk($sformatf("m_data[%0d]", i), m_data, e[i]);
      chk($sformatf("m_last[%0d]", i), m_last, (i == 3));
      @(negedge CLK); #1;
    end
    m_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; abort = 1'b0; req_z = 3'b001;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    fill_tab(0, 63, 8'h00);
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(negedge CLK);
    rst_n = 1'b1;

    // Z=27, zero shifts: every row is XOR of 1..20 = 20
    for (int j = 0; j < 20; j++) send_beat(81'(j + 1));
    s_valid = 1'b0;
    recv(81'd20, 81'd20, 81'd20, 81'd20, 0);
    chk("next_cw_ready", s_ready, 1);

    // Z=27, single shift-1 block in row 0, everything else null
    fill_tab(0, 63, 8'hFF);
    shift_tab[0][0] = 8'd1;
    send_beat(81'h1);
    for (int j = 1; j < 20; j++) send_beat(81'h5A5A5);
    s_valid = 1'b0;
    recv(81'h4000000, 81'h0, 81'h0, 81'h0, 0);

    // Z=81, shift 80 in row 2 col 5, with m_ready stalled 5 cycles
    req_z = 3'b100;
    #1;
    chk("rom_addr_idle_z81", rom_addr, 40);
    shift_tab[45][2] = 8'd80;
    for (int j = 0; j < 20; j++) send_beat(81'h1);
    s_valid = 1'b0;
    recv(81'h0, 81'h0, 81'h2, 81'h0, 5);

    // abort after 7 beats, then full codeword with a mid-codeword req_z change
    req_z = 3'b001;
    fill_tab(0, 19, 8'h00);
    for (int j = 0; j < 7; j++) send_beat(81'hABC + 81'(j));
    s_valid = 1'b0;
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_s_ready", s_ready, 1);
    chk("abort_rom_addr", rom_addr, 0);
    for (int j = 0; j < 20; j++) begin
      if (j == 3) req_z = 3'b100;
      send_beat(81'(j + 1));
    end
    s_valid = 1'b0;
    req_z = 3'b001;
    recv(81'd20, 81'd20, 81'd20, 81'd20, 0);

    // async reset mid-codeword
    for (int j = 0; j < 5; j++) send_beat(81'h3);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_s_ready", s_ready, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_rom_addr", rom_addr, 0);
    @(negedge CLK);
    rst_n = 1'b1;

`ifdef QCLDPC_ZSEL_CHECK_EN
    req_z = 3'b011;
    s_valid = 1'b1;
    s_data = 81'h1;
    #1;
    chk("cfg_err_c0", cfg_err, 1);
    chk("cfg_s_ready_c0", s_ready, 0);
    @(negedge CLK); #1;
    chk("cfg_err_c1", cfg_err, 1);
    chk("cfg_s_ready_c1", s_ready, 0);
    s_valid = 1'b0;
    #1;
    chk("cfg_err_idle", cfg_err, 0);
    req_z = 3'b001;
`else
    req_z = 3'b011;
    #1;
    chk("cfg_rom_addr_lowbit", rom_addr, 0);
`endif
    for (int j = 0; j < 20; j++) send_beat(81'(j + 1));
    s_valid = 1'b0;
    chk("cfg_err_quiet", cfg_err, 0);
    recv(81'd20, 81'd20, 81'd20, 81'd20, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
